// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART, TX and RX sharing one programmable oversampling baud tick.
// Optional build macro UART_LOOPBACK_EN adds i_loopback, which feeds RX from the internal TX line.
module uart_param #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DIV_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  i_baud_div,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_busy,
    output logic                  serial_out,
    input  logic                  serial_in,
`ifdef UART_LOOPBACK_EN
    input  logic                  i_loopback,
`endif
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_is_valid,
    output logic                  rx_parity_error,
    output logic                  rx_frame_error,
    output logic                  rx_busy
);

    localparam int unsigned CNT_W = $clog2(2 * OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam bit          HAS_PAR = (PARITY_MODE != 0);
    localparam logic        PAR_ODD = (PARITY_MODE == 2);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_END = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Baud generator; ">=" recovers at once if the divisor is lowered while the counter is above it
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic                 tick;
    assign tick = (baud_cnt >= i_baud_div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) baud_cnt <= '0;
        else        baud_cnt <= tick ? '0 : baud_cnt + DIV_WIDTH'(1);
    end

    // Transmitter state and next-state signals
    tx_state_t             tx_state, tx_state_n;
    logic [CNT_W-1:0]      tx_cnt, tx_cnt_n;
    logic [BIT_W-1:0]      tx_bit, tx_bit_n;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
    logic                  tx_par, tx_par_n;
    logic                  tx_busy_n;
    logic                  tx_line, tx_line_n;
    logic                  rx_src;

    // Line changes on the tick that opens each bit, so every bit spans exactly OVERSAMPLE ticks
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_busy_n  = o_busy;
        tx_line_n  = tx_line;
        case (tx_state)
            TX_IDLE: begin
                tx_line_n = 1'b1;
                if (enable) begin
                    tx_state_n = TX_START;
                    tx_busy_n  = 1'b1;
                    tx_shift_n = i_data;
                    tx_par_n   = (^i_data) ^ PAR_ODD;
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                end
            end
            TX_START: if (tick) begin
                if (tx_cnt == '0) tx_line_n = 1'b0;
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_DATA;
                end else tx_cnt_n = tx_cnt + CNT_W'(1);
            end
            TX_DATA: if (tick) begin
                if (tx_cnt == '0) tx_line_n = tx_shift[0];
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_shift >> 1;
                    tx_bit_n   = tx_bit + BIT_W'(1);
                    if (tx_bit == DATA_END) tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
                end else tx_cnt_n = tx_cnt + CNT_W'(1);
            end
            TX_PARITY: if (tick) begin
                if (tx_cnt == '0) tx_line_n = tx_par;
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_STOP;
                end else tx_cnt_n = tx_cnt + CNT_W'(1);
            end
            TX_STOP: if (tick) begin
                if (tx_cnt == '0) tx_line_n = 1'b1;
                if (tx_cnt == STOP_END) begin
                    tx_cnt_n   = '0;
                    tx_busy_n  = 1'b0;
                    tx_state_n = TX_IDLE;
                end else tx_cnt_n = tx_cnt + CNT_W'(1);
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            o_busy   <= tx_busy_n;
        end
    end

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_line    <= 1'b1;
            serial_out <= 1'b1;
        end else begin
            tx_line    <= tx_line_n;
            serial_out <= i_loopback ? 1'b1 : tx_line_n;
        end
    end
    assign rx_src = i_loopback ? tx_line : serial_in;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) serial_out <= 1'b1;
        else        serial_out <= tx_line_n;
    end
    assign tx_line = serial_out;
    assign rx_src  = serial_in;
`endif

    // Receiver: 2-FF synchronizer, then mid-bit sampling driven by the shared tick
    logic                  rx_meta, rx_s;
    rx_state_t             rx_state, rx_state_n;
    logic [CNT_W-1:0]      rx_cnt, rx_cnt_n;
    logic [BIT_W-1:0]      rx_bit, rx_bit_n;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
    logic                  rx_par, rx_par_n;
    logic [DATA_WIDTH-1:0] rx_data_n;
    logic                  rx_valid_n, rx_perr_n, rx_ferr_n, rx_busy_n;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_par_n   = rx_par;
        rx_data_n  = received_data;
        rx_valid_n = 1'b0;
        rx_perr_n  = rx_parity_error;
        rx_ferr_n  = rx_frame_error;
        rx_busy_n  = rx_busy;
        case (rx_state)
            RX_IDLE: if (!rx_s) begin
                rx_state_n = RX_START;
                rx_busy_n  = 1'b1;
                rx_cnt_n   = '0;
            end
            RX_START: if (tick) begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt_n = '0;
                    rx_bit_n = '0;
                    if (rx_s) begin
                        rx_state_n = RX_IDLE;
                        rx_busy_n  = 1'b0;
                    end else rx_state_n = RX_DATA;
                end else rx_cnt_n = rx_cnt + CNT_W'(1);
            end
            RX_DATA: if (tick) begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[DATA_WIDTH-1:1]};
                    rx_bit_n   = rx_bit + BIT_W'(1);
                    if (rx_bit == DATA_END) rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
                end else rx_cnt_n = rx_cnt + CNT_W'(1);
            end
            RX_PARITY: if (tick) begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_par_n   = rx_s;
                    rx_state_n = RX_STOP;
                end else rx_cnt_n = rx_cnt + CNT_W'(1);
            end
            RX_STOP: if (tick) begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_data_n  = rx_shift;
                    rx_valid_n = 1'b1;
                    rx_perr_n  = HAS_PAR && (rx_par != ((^rx_shift) ^ PAR_ODD));
                    rx_ferr_n  = ~rx_s;
                    rx_busy_n  = 1'b0;
                    rx_state_n = RX_IDLE;
                end else rx_cnt_n = rx_cnt + CNT_W'(1);
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta         <= 1'b1;
            rx_s            <= 1'b1;
            rx_state        <= RX_IDLE;
            rx_cnt          <= '0;
            rx_bit          <= '0;
            rx_shift        <= '0;
            rx_par          <= 1'b0;
            received_data   <= '0;
            data_is_valid   <= 1'b0;
            rx_parity_error <= 1'b0;
            rx_frame_error  <= 1'b0;
            rx_busy         <= 1'b0;
        end else begin
            rx_meta         <= rx_src;
            rx_s            <= rx_meta;
            rx_state        <= rx_state_n;
            rx_cnt          <= rx_cnt_n;
            rx_bit          <= rx_bit_n;
            rx_shift        <= rx_shift_n;
            rx_par          <= rx_par_n;
            received_data   <= rx_data_n;
            data_is_valid   <= rx_valid_n;
            rx_parity_error <= rx_perr_n;
            rx_frame_error  <= rx_ferr_n;
            rx_busy         <= rx_busy_n;
        end
    end

endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: even-parity/1-stop/x8 instance (externally looped or bench-driven RX) and
// odd-parity/2-stop/x16 instance self-looped, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_param;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [15:0] div0, div1;
    logic        en0, en1;
    logic [7:0]  d0, d1;
    logic        busy0, busy1, so0, so1, si0;
    logic [7:0]  rd0, rd1;
    logic        v0, v1, pe0, pe1, fe0, fe1, rb0, rb1;
    logic        lb, drv_line;

    assign si0 = lb ? so0 : drv_line;

    uart_param #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(8), .DIV_WIDTH(16)) u_even (
        .clk(clk), .reset(rst_n), .i_baud_div(div0), .enable(en0), .i_data(d0), .o_busy(busy0),
        .serial_out(so0), .serial_in(si0), .received_data(rd0), .data_is_valid(v0),
        .rx_parity_error(pe0), .rx_frame_error(fe0), .rx_busy(rb0));

    uart_param #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(16), .DIV_WIDTH(16)) u_odd (
        .clk(clk), .reset(rst_n), .i_baud_div(div1), .enable(en1), .i_data(d1), .o_busy(busy1),
        .serial_out(so1), .serial_in(so1), .received_data(rd1), .data_is_valid(v1),
        .rx_parity_error(pe1), .rx_frame_error(fe1), .rx_busy(rb1));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } rx_t;
    rx_t rxq0[$];
    rx_t rxq1[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) rxq0.push_back(rx_t'{rd0, pe0, fe0, cyc});
        if (v1) rxq1.push_back(rx_t'{rd1, pe1, fe1, cyc});
    end

    // Reference frame: start, data LSB first, optional parity from a count of ones, stop bits
    typedef bit bitq_t[$];
    function automatic bitq_t build_frame(input logic [7:0] data, input int pm, input int sb);
        bitq_t q;
        int    ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(data[i]);
            if (data[i]) ones++;
        end
        if (pm == 1) q.push_back((ones % 2) == 1);
        else if (pm == 2) q.push_back((ones % 2) == 0);
        for (int i = 0; i < sb; i++) q.push_back(1'b1);
        return q;
    endfunction

    function automatic logic cur_busy(input int inst);
        return (inst != 0) ? busy1 : busy0;
    endfunction

    function automatic logic cur_line(input int inst);
        return (inst != 0) ? so1 : so0;
    endfunction

    task automatic set_en(input int inst, input logic e, input logic [7:0] d);
        if (inst != 0) begin en1 = e; d1 = d; end
        else begin en0 = e; d0 = d; end
    endtask

    // Send one word, check busy length, bit waveform and the looped-back receive
    task automatic test_tx_frame(input int inst, input logic [7:0] data, input int div,
                                 input bit inject, input string name);
        bitq_t exp;
        logic  s[$];
        int    busy_len, f, os, per, guard, t, lo, extra_busy, idx;
        rx_t   r;
        os  = (inst != 0) ? 16 : 8;
        per = os * (div + 1);
        exp = build_frame(data, (inst != 0) ? 2 : 1, (inst != 0) ? 2 : 1);
        if (inst != 0) begin div1 = 16'(div); rxq1.delete(); end
        else begin div0 = 16'(div); rxq0.delete(); end
        @(negedge clk); set_en(inst, 1'b1, data);
        @(negedge clk); set_en(inst, 1'b0, data);
        busy_len = 0;
        guard    = 0;
        while (cur_busy(inst) && guard < 5000) begin
            s.push_back(cur_line(inst));
            busy_len++;
            if (inject && busy_len == 10) set_en(inst, 1'b1, ~data);
            if (inject && busy_len == 14) set_en(inst, 1'b0, data);
            @(negedge clk);
            guard++;
        end
        extra_busy = 0;
        for (int k = 0; k < per + 4; k++) begin
            s.push_back(cur_line(inst));
            if (cur_busy(inst)) extra_busy++;
            @(negedge clk);
        end
        t  = exp.size() * os;
        lo = (t - 1) * (div + 1) + 1;
        checks++;
        if (busy_len < lo || busy_len > lo + div) begin
            errors++;
            $display("FAIL %s busy_len got %0d want %0d..%0d", name, busy_len, lo, lo + div);
        end
        checks++;
        if (extra_busy !== 0) begin
            errors++;
            $display("FAIL %s restart_after_frame got %0d busy cycles want 0", name, extra_busy);
        end
        f = -1;
        foreach (s[i]) if (f < 0 && s[i] === 1'b0) f = i;
        checks++;
        if (f < 1 || f > div + 1) begin
            errors++;
            $display("FAIL %s start_offset got %0d want 1..%0d", name, f, div + 1);
        end
        if (f >= 1) begin
            foreach (exp[b]) begin
                for (int k = 0; k < 2; k++) begin
                    idx = f + b * per + ((k == 0) ? 0 : per - 1);
                    checks++;
                    if (idx >= s.size() || s[idx] !== exp[b]) begin
                        errors++;
                        $display("FAIL %s line_bit%0d got %b want %b", name, b,
                                 (idx < s.size()) ? s[idx] : 1'bx, exp[b]);
                    end
                end
            end
        end
        checks++;
        if (((inst != 0) ? rxq1.size() : rxq0.size()) != 1) begin
            errors++;
            $display("FAIL %s rx_count got %0d want 1", name, (inst != 0) ? rxq1.size() : rxq0.size());
        end else begin
            r = (inst != 0) ? rxq1[0] : rxq0[0];
            checks++;
            if (r.d !== data || r.pe !== 1'b0 || r.fe !== 1'b0) begin
                errors++;
                $display("FAIL %s rx_word got %h pe %b fe %b want %h pe 0 fe 0", name, r.d, r.pe, r.fe, data);
            end
        end
    endtask

    // Bench-driven RX frame on the even instance at one clk per tick
    task automatic drive_frame(input logic [7:0] data, input bit flip_par, input bit stop_val,
                               output int start);
        bitq_t q;
        q = build_frame(data, 1, 1);
        if (flip_par) q[9] = ~q[9];
        q[10] = stop_val;
        @(negedge clk);
        start = cyc;
        foreach (q[i]) begin
            drv_line = q[i];
            repeat (8) @(negedge clk);
        end
        drv_line = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({so0, so1} !== 2'b11) begin
            errors++; $display("FAIL reset serial_out got %b want 11", {so0, so1});
        end
        checks++;
        if ({busy0, busy1, rb0, rb1} !== 4'b0) begin
            errors++; $display("FAIL reset busy got %b want 0000", {busy0, busy1, rb0, rb1});
        end
        checks++;
        if ({v0, pe0, fe0, v1, pe1, fe1} !== 6'b0) begin
            errors++; $display("FAIL reset rx_flags got %b want 000000", {v0, pe0, fe0, v1, pe1, fe1});
        end
        checks++;
        if (rd0 !== 8'h00 || rd1 !== 8'h00) begin
            errors++; $display("FAIL reset received_data got %h/%h want 00/00", rd0, rd1);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rx_errors;
        int  st;
        rx_t r;
        logic [7:0] w;
        lb = 1'b0; drv_line = 1'b1; div0 = 16'd0;
        repeat (4) @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            w = (n == 0) ? 8'h3C : 8'($urandom);
            rxq0.delete();
            drive_frame(w, n == 1, n != 0, st);
            checks++;
            if (rxq0.size() != 1) begin
                errors++; $display("FAIL rx_err%0d rx_count got %0d want 1", n, rxq0.size());
            end else begin
                r = rxq0[0];
                checks++;
                if (r.d !== w || r.pe !== (n == 1) || r.fe !== (n == 0)) begin
                    errors++;
                    $display("FAIL rx_err%0d word got %h pe %b fe %b want %h pe %b fe %b",
                             n, r.d, r.pe, r.fe, w, n == 1, n == 0);
                end
                checks++;
                if (r.cyc - st < 86 || r.cyc - st > 88) begin
                    errors++; $display("FAIL rx_err%0d latency got %0d want 86..88", n, r.cyc - st);
                end
            end
            checks++;
            if (pe0 !== (n == 1) || fe0 !== (n == 0) || rb0 !== 1'b0) begin
                errors++;
                $display("FAIL rx_err%0d held_flags got pe %b fe %b busy %b want pe %b fe %b busy 0",
                         n, pe0, fe0, rb0, n == 1, n == 0);
            end
        end
    endtask

    task automatic test_false_start;
        int g, len;
        lb = 1'b0; drv_line = 1'b1; div0 = 16'd0; rxq0.delete();
        @(negedge clk); drv_line = 1'b0;
        repeat (2) @(negedge clk);
        drv_line = 1'b1;
        g = 0;
        while (!rb0 && g < 10) begin @(negedge clk); g++; end
        len = 0;
        while (rb0 && len < 40) begin @(negedge clk); len++; end
        checks++;
        if (len < 4 || len > 5) begin
            errors++; $display("FAIL glitch rx_busy_len got %0d want 4..5", len);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (rxq0.size() != 0) begin
            errors++; $display("FAIL glitch rx_count got %0d want 0", rxq0.size());
        end
    endtask

    task automatic test_reset_midframe;
        lb = 1'b1; div0 = 16'd0;
        @(negedge clk); set_en(0, 1'b1, 8'hF0);
        @(negedge clk); set_en(0, 1'b0, 8'hF0);
        repeat (36) @(negedge clk);
        checks++;
        if (so0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++; $display("FAIL midframe pre_reset got line %b busy %b want 0 1", so0, busy0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (so0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL midframe async_reset got line %b busy %b want 1 0", so0, busy0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_tx_frame(0, 8'h55, 0, 1'b0, "after_reset_55");
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b;
        int g, gap;
        lb = 1'b1; div0 = 16'd0; rxq0.delete();
        a = 8'($urandom); b = 8'($urandom);
        @(negedge clk); set_en(0, 1'b1, a);
        @(negedge clk); d0 = b;
        g = 0;
        while (busy0 && g < 2000) begin @(negedge clk); g++; end
        gap = 0;
        while (!busy0 && gap < 10) begin @(negedge clk); gap++; end
        en0 = 1'b0;
        checks++;
        if (gap != 1) begin
            errors++; $display("FAIL b2b idle_gap got %0d want 1", gap);
        end
        g = 0;
        while ((busy0 || rb0) && g < 2000) begin @(negedge clk); g++; end
        repeat (10) @(negedge clk);
        checks++;
        if (rxq0.size() != 2) begin
            errors++; $display("FAIL b2b rx_count got %0d want 2", rxq0.size());
        end else begin
            checks++;
            if (rxq0[0].d !== a || rxq0[1].d !== b || {rxq0[0].pe, rxq0[0].fe, rxq0[1].pe, rxq0[1].fe} !== 4'b0) begin
                errors++;
                $display("FAIL b2b words got %h %h flags %b want %h %h flags 0000", rxq0[0].d, rxq0[1].d,
                         {rxq0[0].pe, rxq0[0].fe, rxq0[1].pe, rxq0[1].fe}, a, b);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        en0 = 1'b0; en1 = 1'b0; d0 = '0; d1 = '0;
        div0 = '0; div1 = '0; lb = 1'b1; drv_line = 1'b1;
        test_reset();
        test_tx_frame(0, 8'hA5, 0, 1'b0, "even_a5");
        test_tx_frame(1, 8'hA5, 0, 1'b0, "odd_a5");
        test_tx_frame(0, 8'h96, 0, 1'b1, "busy_ignore_96");
        for (int n = 0; n < 4; n++)
            test_tx_frame(0, 8'($urandom), int'($urandom_range(0, 2)), 1'b0, "even_rand");
        for (int n = 0; n < 2; n++)
            test_tx_frame(1, 8'($urandom), int'($urandom_range(0, 1)), 1'b0, "odd_rand");
        test_rx_errors();
        test_false_start();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_param.md
# uart_param

Parametrised full-duplex UART core: one transmitter and one receiver sharing a runtime-programmable oversampling baud generator. Data width, parity mode, stop-bit count and oversampling ratio are set by parameters. The core is the successor to the fixed 8-bit even-parity UART and sits between the system bus logic and the serial pins. Parity and framing errors are reported per received word.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, legal range 5–9.
- `PARITY_MODE`, 1: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits transmitted, 1 or 2.
- `OVERSAMPLE`, 16: oversample ticks per bit, 8 or 16.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `i_baud_div`, input, DIV_WIDTH: oversample tick period is `i_baud_div`+1 clk cycles.
- `enable`, input, 1: transmit request; accepted only when `o_busy`=0.
- `i_data`, input, DATA_WIDTH: transmit word, sampled on the accepted `enable` cycle.
- `o_busy`, output, 1: transmitter busy.
- `serial_out`, output, 1: TX line, idles high.
- `serial_in`, input, 1: RX line, asynchronous.
- `received_data`, output, DATA_WIDTH: last received word.
- `data_is_valid`, output, 1: one-cycle pulse when a new word is delivered.
- `rx_parity_error`, output, 1: parity error flag, qualified by `data_is_valid`.
- `rx_frame_error`, output, 1: frame error flag, qualified by `data_is_valid`.
- `rx_busy`, output, 1: receiver is inside a frame.

## Operation
- **Reset values** (while `reset`=0): `serial_out`=1; `o_busy`, `rx_busy`, `data_is_valid` and both error flags = 0; `received_data`=0; all counters and FSMs cleared. Assertion mid-frame aborts both directions immediately; `serial_out` returns high asynchronously.
- **Baud generator:** a free-running counter runs 0..`i_baud_div` and emits a one-cycle `tick` at the terminal count. `i_baud_div`=0 produces a tick every cycle. `i_baud_div` must be static while `o_busy` or `rx_busy` is high; behaviour is otherwise unspecified.
- **TX FSM** states: IDLE → START → DATA → PARITY (skipped if `PARITY_MODE`=0) → STOP → IDLE.
  - `enable`=1 while in IDLE latches `i_data`; `o_busy` goes high on the next cycle.
  - `enable` while `o_busy`=1 is ignored.
  - Each bit lasts exactly OVERSAMPLE ticks. Data is sent LSB first.
  - Even parity bit = XOR of the data bits; odd parity bit = its inverse.
  - STOP lasts STOP_BITS×OVERSAMPLE ticks. `o_busy` drops on the cycle after the final stop tick.
- **RX path:**
  - `serial_in` passes through a 2-FF synchronizer.
  - IDLE: a synchronized low value moves the FSM to START and sets `rx_busy`.
  - START: after OVERSAMPLE/2 ticks the line is resampled. If high, it is a false start: return to IDLE and clear `rx_busy`. If low, proceed.
  - DATA and PARITY bits are sampled every OVERSAMPLE ticks thereafter, at bit centres. STOP is sampled once, at the centre of the first stop bit.
  - On the stop sample: update `received_data`, pulse `data_is_valid`, and set `rx_parity_error` (mismatch; always 0 when `PARITY_MODE`=0) and `rx_frame_error` (stop sampled low).
  - Data is delivered even when an error is flagged. The flags hold until the next `data_is_valid`.
  - The FSM returns to IDLE and clears `rx_busy` on the cycle after the stop sample. Only one stop bit is required on receive.
- TX and RX are fully independent; simultaneous activity is legal.

## Timing
- `enable` accepted at cycle N: `o_busy`=1 at N+1. The start bit (`serial_out`=0) begins at the first tick after N.
- TX frame length = (1 + DATA_WIDTH + (PARITY_MODE≠0) + STOP_BITS) × OVERSAMPLE ticks.
- RX latency: from the first synchronized low, `data_is_valid` fires after (OVERSAMPLE/2 + (DATA_WIDTH + (PARITY_MODE≠0) + 1) × OVERSAMPLE) ticks, plus ≤1 tick of alignment. The synchronizer adds 2 clk of latency ahead of that.
- A back-to-back `enable` on the cycle `o_busy` falls is accepted. There are no idle bits between frames beyond the stop bits.

## Configuration
- `UART_LOOPBACK_EN`
  - Defined: adds input port `i_loopback` (1 bit). When `i_loopback`=1, the RX synchronizer input is taken from the internal TX line instead of `serial_in`, and `serial_out` is held at 1.
  - Undefined: the port is absent and RX is always fed from `serial_in`.

## Test plan
- DATA_WIDTH=8, PARITY_MODE=1, OVERSAMPLE=8, `i_baud_div`=0, send 0xA5 → `serial_out` = 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 8 clk. `o_busy` is high for exactly 88 clk.
- Same frame with loopback enabled → a single `data_is_valid` pulse, `received_data`=0xA5, both error flags 0. Repeat with PARITY_MODE=2 → parity bit is 1 and there is no error.
- Drive `serial_in` with a 0x3C frame whose stop bit is 0 → `data_is_valid`, `received_data`=0x3C, `rx_frame_error`=1, `rx_parity_error`=0.
- Low glitch of 2 ticks on `serial_in` (OVERSAMPLE=16) → no `data_is_valid`, and `rx_busy` returns to 0 after 8 ticks.
- Pulse `reset` low during TX data bit 3 → `serial_out`=1 and `o_busy`=0 immediately; the next `enable` with 0x55 produces a complete, correct frame.
- `enable` pulsed while `o_busy`=1 with a different `i_data` → ignored; the first frame completes unchanged.
